// File: rtl/fpu_issue_wb_ctrl.sv
// fpu_issue_wb_ctrl: issue/writeback sequencer around the FPU with sticky fflags and a watchdog
module fpu_issue_wb_ctrl #(
    parameter int TAG_W   = 5,
    parameter int MAX_LAT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic             req_rs2_lsb,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             fpu_start,
    output logic [4:0]       fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_rs2_lsb,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_done,
    input  logic             fpu_nv,
    input  logic             fpu_dz,
    input  logic             fpu_of,
    input  logic             fpu_uf,
    input  logic             fpu_nx,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic [4:0]       wb_flags,
    input  logic             csr_fflags_we,
    input  logic [4:0]       csr_fflags_wdata,
    output logic [4:0]       csr_fflags,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP, DRAIN} state_t;
    state_t            state, state_n;
    logic [7:0]        cnt;
    logic [TAG_W-1:0]  tag_q;
    logic [4:0]        flags;
    logic              accept, capture, timeout, expire;
    assign flags     = {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
    assign req_ready = (state == IDLE) && !flush;
    assign wb_valid  = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign expire    = cnt >= 8'(MAX_LAT - 1);
    always_comb begin
        state_n = state;
        capture = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE:  state_n = accept ? EXEC : IDLE;
            EXEC: begin
                if (fpu_done) begin
                    capture = !flush;
                    state_n = flush ? IDLE : RESP;
                end else if (flush) begin
                    state_n = DRAIN;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:  state_n = (wb_ready || flush) ? IDLE : RESP;
            DRAIN: state_n = (fpu_done || expire) ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tag_q       <= '0;
            fpu_start   <= 1'b0;
            fpu_op      <= '0;
            fpu_rm      <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_rs2_lsb <= 1'b0;
            wb_data     <= '0;
            wb_tag      <= '0;
            wb_flags    <= '0;
            csr_fflags  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_n;
            // start is held for the whole time the FPU owns the request, including a drain
            fpu_start <= (state_n == EXEC) || (state_n == DRAIN);
            cnt       <= accept ? 8'd0 : ((state == EXEC) || (state == DRAIN)) ? cnt + 8'd1 : cnt;
            if (accept) begin
                fpu_op      <= req_op;
                fpu_rm      <= req_rm;
                fpu_a       <= req_a;
                fpu_b       <= req_b;
                fpu_rs2_lsb <= req_rs2_lsb;
                tag_q       <= req_tag;
            end
            if (capture || timeout) begin
                wb_data  <= timeout ? 32'h7FC0_0000 : fpu_result;
                wb_flags <= timeout ? 5'b10000 : flags;
                wb_tag   <= tag_q;
            end
            csr_fflags  <= (csr_fflags_we ? csr_fflags_wdata : csr_fflags) | (capture ? flags : 5'b0);
            timeout_err <= timeout_err || timeout;
        end
    end
endmodule

// File: tb/tb_fpu_issue_wb_ctrl.sv
// tb_fpu_issue_wb_ctrl: directed vectors against hand-computed expectations
module tb_fpu_issue_wb_ctrl;
    logic        clk = 0, reset = 0;
    logic        req_valid = 0, req_ready, req_rs2_lsb = 0, flush = 0;
    logic [4:0]  req_op = 0, req_tag = 0;
    logic [2:0]  req_rm = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        fpu_start, fpu_rs2_lsb;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a, fpu_b, fpu_result = 0;
    logic        fpu_done = 0, fpu_nv = 0, fpu_dz = 0, fpu_of = 0, fpu_uf = 0, fpu_nx = 0;
    logic        wb_valid, wb_ready = 1;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag, wb_flags, csr_fflags;
    logic        csr_fflags_we = 0;
    logic [4:0]  csr_fflags_wdata = 0;
    logic        timeout_err;
    int          n_cmp = 0, n_err = 0, n;
    fpu_issue_wb_ctrl #(.TAG_W(5), .MAX_LAT(63)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rm(req_rm), .req_rs2_lsb(req_rs2_lsb), .req_a(req_a),
        .req_b(req_b), .req_tag(req_tag), .flush(flush), .fpu_start(fpu_start),
        .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_result(fpu_result), .fpu_done(fpu_done),
        .fpu_nv(fpu_nv), .fpu_dz(fpu_dz), .fpu_of(fpu_of), .fpu_uf(fpu_uf),
        .fpu_nx(fpu_nx), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_flags(wb_flags), .csr_fflags_we(csr_fflags_we),
        .csr_fflags_wdata(csr_fflags_wdata), .csr_fflags(csr_fflags), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a, b, input logic [4:0] tag);
        req_op = op; req_rm = rm; req_a = a; req_b = b; req_tag = tag; req_valid = 1;
        tick;
        req_valid = 0;
    endtask
    // Plays the FPU: done on start cycle lat (0 = never), optional flush on start cycle fl_at
    task automatic exec(input int lat, input logic [31:0] res, input logic [4:0] fl, input int fl_at, output int cycles);
        cycles = 0;
        while (fpu_start && cycles < 300) begin
            cycles++;
            if (cycles == lat) begin
                fpu_done = 1; fpu_result = res;
                {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = fl;
            end
            if (cycles == fl_at) flush = 1;
            tick;
            fpu_done = 0; flush = 0;
            {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = 5'b0;
        end
    endtask
    initial begin
        tick; tick;
        check("rst_start", fpu_start, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_fflags", csr_fflags, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1;
        tick;
        check("idle_ready", req_ready, 1);
        // FADD 1.0 + 2.0, dynamic rm passed through
        issue(5'b00000, 3'b111, 32'h3F80_0000, 32'h4000_0000, 5'd3);
        check("t1_start", fpu_start, 1);
        check("t1_a", fpu_a, 32'h3F80_0000);
        check("t1_b", fpu_b, 32'h4000_0000);
        check("t1_rm", fpu_rm, 3'b111);
        check("t1_wb_early", wb_valid, 0);
        fpu_done = 1; fpu_result = 32'h4040_0000;
        tick;
        fpu_done = 0;
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_data", wb_data, 32'h4040_0000);
        check("t1_wb_flags", wb_flags, 0);
        check("t1_wb_tag", wb_tag, 5'd3);
        check("t1_start_low", fpu_start, 0);
        tick;
        check("t1_wb_done", wb_valid, 0);
        // FDIV, 25 cycles, DZ, then back-pressure
        wb_ready = 0;
        issue(5'b00011, 3'b000, 32'h3F80_0000, 32'h0000_0000, 5'd7);
        exec(25, 32'h7F80_0000, 5'b01000, 0, n);
        check("t2_start_cycles", n, 25);
        check("t2_wb_flags", wb_flags, 5'b01000);
        check("t2_fflags", csr_fflags, 5'b01000);
        req_valid = 1; req_a = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_valid", wb_valid, 1);
            check("t3_hold_data", wb_data, 32'h7F80_0000);
            check("t3_hold_ready", req_ready, 0);
            tick;
        end
        wb_ready = 1;
        tick;
        check("t3_released", wb_valid, 0);
        check("t3_no_accept", fpu_start, 0);
        req_valid = 0;
        // flush on cycle 3 of a 10-cycle FDIV
        issue(5'b00011, 3'b001, 32'h4000_0000, 32'h4040_0000, 5'd9);
        exec(10, 32'h3F2A_AAAB, 5'b00101, 3, n);
        check("t4_drain_cycles", n, 10);
        check("t4_no_wb", wb_valid, 0);
        check("t4_fflags", csr_fflags, 5'b01000);
        check("t4_idle", req_ready, 1);
        // flush coinciding with done discards the result
        issue(5'b00001, 3'b000, 32'h1, 32'h2, 5'd1);
        exec(2, 32'hDEAD_BEEF, 5'b10000, 2, n);
        check("fd_cycles", n, 2);
        check("fd_no_wb", wb_valid, 0);
        check("fd_fflags", csr_fflags, 5'b01000);
        // flush in IDLE blocks accept
        flush = 1; req_valid = 1;
        check("fi_ready", req_ready, 0);
        tick;
        flush = 0; req_valid = 0;
        check("fi_no_start", fpu_start, 0);
        // plain CSR write
        csr_fflags_we = 1; csr_fflags_wdata = 5'b10110;
        tick;
        csr_fflags_we = 0;
        check("csr_write", csr_fflags, 5'b10110);
        // CSR write of zero in the capture cycle of an NX op
        issue(5'b00010, 3'b000, 32'h3F80_0000, 32'h4040_0000, 5'd4);
        fpu_done = 1; fpu_nx = 1; fpu_result = 32'h3EAA_AAAB;
        csr_fflags_we = 1; csr_fflags_wdata = 5'b00000;
        tick;
        fpu_done = 0; fpu_nx = 0; csr_fflags_we = 0;
        check("t5_fflags", csr_fflags, 5'b00001);
        check("t5_wb_flags", wb_flags, 5'b00001);
        tick;
        // flush while in RESP
        wb_ready = 0;
        issue(5'b00010, 3'b000, 32'h0080_0000, 32'h4000_0000, 5'd5);
        exec(1, 32'h0040_0000, 5'b00010, 0, n);
        check("fr_valid", wb_valid, 1);
        flush = 1;
        tick;
        flush = 0;
        check("fr_dropped", wb_valid, 0);
        check("fr_fflags", csr_fflags, 5'b00011);
        // watchdog
        issue(5'b00011, 3'b000, 32'h1, 32'h1, 5'd6);
        exec(0, 32'h0, 5'b0, 0, n);
        check("t6_cycles", n, 63);
        check("t6_wb_valid", wb_valid, 1);
        check("t6_wb_data", wb_data, 32'h7FC0_0000);
        check("t6_wb_flags", wb_flags, 5'b10000);
        check("t6_timeout", timeout_err, 1);
        check("t6_wb_tag", wb_tag, 5'd6);
        wb_ready = 1;
        tick;
        check("t6_sticky", timeout_err, 1);
        // reset mid-operation
        issue(5'b00011, 3'b000, 32'h1, 32'h1, 5'd2);
        tick;
        reset = 0;
        tick;
        reset = 1;
        check("mr_start", fpu_start, 0);
        check("mr_wb", wb_valid, 0);
        check("mr_timeout", timeout_err, 0);
        check("mr_fflags", csr_fflags, 0);
        tick;
        check("mr_ready", req_ready, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
